// File: rtl/mem_arbiter.sv
// Two-master (fetch / load-store) to one-slave memory port arbiter and sequencer.
// Accepts one request at a time, with a watchdog that ends hung transactions in an error response.
module mem_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          ifu_req_valid,
  output logic          ifu_req_ready,
  input  logic [AW-1:0] ifu_addr,
  output logic          ifu_resp_valid,
  output logic [DW-1:0] ifu_rdata,
  output logic          ifu_resp_err,

  input  logic          lsu_req_valid,
  output logic          lsu_req_ready,
  input  logic [AW-1:0] lsu_addr,
  input  logic          lsu_wen,
  input  logic [DW-1:0] lsu_wdata,
  input  logic [7:0]    lsu_wmask,
  input  logic [2:0]    lsu_readop,
  output logic          lsu_resp_valid,
  output logic [DW-1:0] lsu_rdata,
  output logic          lsu_resp_err,

  output logic          mem_req_valid,
  input  logic          mem_req_ready,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wen,
  output logic [DW-1:0] mem_wdata,
  output logic [7:0]    mem_wmask,
  output logic [2:0]    mem_readop,
  input  logic          mem_resp_valid,
  input  logic [DW-1:0] mem_rdata,

  output logic [1:0]    grant
);

  localparam int unsigned CW  = 16;
  localparam int unsigned MW  = 8;
  localparam int unsigned OPW = 3;

  localparam logic [1:0]     GRANT_NONE = 2'b00;
  localparam logic [1:0]     GRANT_IFU  = 2'b01;
  localparam logic [1:0]     GRANT_LSU  = 2'b10;
  localparam logic [OPW-1:0] IFU_READOP = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [1:0]     grant_q, grant_d;
  logic           last_lsu_q, last_lsu_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           err_q, err_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic           wen_q, wen_d;
  logic [DW-1:0]  wdata_q, wdata_d;
  logic [MW-1:0]  wmask_q, wmask_d;
  logic [OPW-1:0] readop_q, readop_d;
  logic [DW-1:0]  ifu_rdata_q, ifu_rdata_d;
  logic [DW-1:0]  lsu_rdata_q, lsu_rdata_d;

  logic          ifu_win, lsu_win;
  logic [CW-1:0] cnt_inc;
  logic          timeout;
  logic          resp_capture;
  logic          timeout_fire;

  // Arbitration: a tie goes to the requester that did not win last time.
  always_comb begin
    ifu_win = 1'b0;
    lsu_win = 1'b0;
    if (!rst && state_q == S_IDLE) begin
      lsu_win = lsu_req_valid && (!ifu_req_valid || !last_lsu_q);
      ifu_win = ifu_req_valid && (!lsu_req_valid ||  last_lsu_q);
    end
  end

  // Watchdog: fires on the TIMEOUT-th cycle spent in REQ+WAIT; a real response in that cycle wins.
  always_comb begin
    cnt_inc      = cnt_q + CW'(1);
    timeout      = (TIMEOUT != 0) && (cnt_inc == CW'(TIMEOUT));
    resp_capture = (state_q == S_WAIT) && mem_resp_valid;
    timeout_fire = ((state_q == S_REQ) || (state_q == S_WAIT)) && timeout && !resp_capture;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (ifu_win || lsu_win) state_d = S_REQ;
      end
      S_REQ: begin
        if (timeout_fire)       state_d = S_RESP;
        else if (mem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (resp_capture || timeout_fire) state_d = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ifu_req_ready  = ifu_win;
    lsu_req_ready  = lsu_win;
    mem_req_valid  = (state_q == S_REQ);
    ifu_resp_valid = (state_q == S_RESP) && (grant_q == GRANT_IFU);
    lsu_resp_valid = (state_q == S_RESP) && (grant_q == GRANT_LSU);
    ifu_resp_err   = ifu_resp_valid && err_q;
    lsu_resp_err   = lsu_resp_valid && err_q;
  end

  // Request latch, ownership tracking and response data capture.
  always_comb begin
    grant_d     = grant_q;
    last_lsu_d  = last_lsu_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    addr_d      = addr_q;
    wen_d       = wen_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    readop_d    = readop_q;
    ifu_rdata_d = ifu_rdata_q;
    lsu_rdata_d = lsu_rdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (ifu_win) begin
          grant_d    = GRANT_IFU;
          last_lsu_d = 1'b0;
          addr_d     = ifu_addr;
          wen_d      = 1'b0;
          wdata_d    = '0;
          wmask_d    = '0;
          readop_d   = IFU_READOP;
          cnt_d      = '0;
          err_d      = 1'b0;
        end else if (lsu_win) begin
          grant_d    = GRANT_LSU;
          last_lsu_d = 1'b1;
          addr_d     = lsu_addr;
          wen_d      = lsu_wen;
          wdata_d    = lsu_wdata;
          wmask_d    = lsu_wmask;
          readop_d   = lsu_readop;
          cnt_d      = '0;
          err_d      = 1'b0;
        end
      end
      S_REQ, S_WAIT: begin
        cnt_d = cnt_inc;
        if (resp_capture) begin
          err_d = 1'b0;
          if (grant_q == GRANT_IFU) ifu_rdata_d = mem_rdata;
          else                      lsu_rdata_d = wen_q ? '0 : mem_rdata;
        end else if (timeout_fire) begin
          err_d = 1'b1;
          if (grant_q == GRANT_IFU) ifu_rdata_d = '0;
          else                      lsu_rdata_d = '0;
        end
      end
      S_RESP: begin
        grant_d = GRANT_NONE;
      end
      default: grant_d = GRANT_NONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q     <= GRANT_NONE;
      last_lsu_q  <= 1'b0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      wen_q       <= 1'b0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      readop_q    <= '0;
      ifu_rdata_q <= '0;
      lsu_rdata_q <= '0;
    end else begin
      grant_q     <= grant_d;
      last_lsu_q  <= last_lsu_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      addr_q      <= addr_d;
      wen_q       <= wen_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      readop_q    <= readop_d;
      ifu_rdata_q <= ifu_rdata_d;
      lsu_rdata_q <= lsu_rdata_d;
    end
  end

  assign grant      = grant_q;
  assign mem_addr   = addr_q;
  assign mem_wen    = wen_q;
  assign mem_wdata  = wdata_q;
  assign mem_wmask  = wmask_q;
  assign mem_readop = readop_q;
  assign ifu_rdata  = ifu_rdata_q;
  assign lsu_rdata  = lsu_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: expected responses queued at request time,
// checked whenever the arbiter raises a resp_valid.
module tb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_err;
  logic [AW-1:0] ifu_addr;
  logic [DW-1:0] ifu_rdata;
  logic          lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_err;
  logic [AW-1:0] lsu_addr;
  logic [DW-1:0] lsu_wdata, lsu_rdata;
  logic [7:0]    lsu_wmask;
  logic [2:0]    lsu_readop;
  logic          mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [7:0]    mem_wmask;
  logic [2:0]    mem_readop;
  logic [1:0]    grant;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic          lsu;
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata), .ifu_resp_err(ifu_resp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask), .lsu_readop(lsu_readop),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata), .lsu_resp_err(lsu_resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_readop(mem_readop),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .grant(grant)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pops the scoreboard on any response pulse; a pulse with nothing queued is an error.
  task automatic mon();
    exp_t e;
    if (ifu_resp_valid || lsu_resp_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_resp", 64'({ifu_resp_valid, lsu_resp_valid}), 64'(0));
      end else begin
        e = sb.pop_front();
        chk("resp_owner", 64'({lsu_resp_valid, ifu_resp_valid}), e.lsu ? 64'(2'b10) : 64'(2'b01));
        chk("resp_rdata", e.lsu ? 64'(lsu_rdata) : 64'(ifu_rdata), 64'(e.data));
        chk("resp_err", e.lsu ? 64'(lsu_resp_err) : 64'(ifu_resp_err), 64'(e.err));
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
    mon();
  endtask

  // Memory side: accept after rdy_dly stalled REQ cycles, respond after rsp_dly idle WAIT cycles.
  task automatic mem_serve(input int rdy_dly, input int rsp_dly, input logic [DW-1:0] rd,
                           input logic [AW-1:0] ea, input logic ew, input logic [DW-1:0] ewd,
                           input logic [7:0] em, input logic [2:0] eo);
    for (int i = 0; i <= rdy_dly; i++) begin
      chk("mem_req_valid", 64'(mem_req_valid), 64'(1));
      chk("mem_addr", 64'(mem_addr), 64'(ea));
      chk("mem_wen", 64'(mem_wen), 64'(ew));
      chk("mem_wdata", 64'(mem_wdata), 64'(ewd));
      chk("mem_wmask", 64'(mem_wmask), 64'(em));
      chk("mem_readop", 64'(mem_readop), 64'(eo));
      mem_req_ready = (i == rdy_dly);
      step();
    end
    mem_req_ready = 1'b0;
    for (int i = 0; i < rsp_dly; i++) begin
      chk("wait_no_req", 64'(mem_req_valid), 64'(0));
      step();
    end
    mem_resp_valid = 1'b1;
    mem_rdata      = rd;
    step();
    mem_resp_valid = 1'b0;
    mem_rdata      = '0;
  endtask

  initial begin
    rst = 1'b1;
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_2000; lsu_wen = 1'b0;
    lsu_wdata = '0; lsu_wmask = '0; lsu_readop = 3'b100;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_rdata = '0;

    // Reset state, with both requesters already valid.
    step(); step();
    chk("rst_ifu_ready", 64'(ifu_req_ready), 64'(0));
    chk("rst_lsu_ready", 64'(lsu_req_ready), 64'(0));
    chk("rst_grant", 64'(grant), 64'(0));
    chk("rst_mem_req_valid", 64'(mem_req_valid), 64'(0));
    chk("rst_mem_fields", 64'({mem_addr, mem_wen, mem_wmask, mem_readop}), 64'(0));
    chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    chk("rst_rdata", 64'({ifu_rdata, lsu_rdata}), 64'(0));
    chk("rst_resp", 64'({ifu_resp_valid, lsu_resp_valid, ifu_resp_err, lsu_resp_err}), 64'(0));
    mem_req_ready = 1'b0;

    // First tie after reset goes to LSU (load).
    rst = 1'b0;
    #1;
    chk("tie1_lsu_ready", 64'(lsu_req_ready), 64'(1));
    chk("tie1_ifu_ready", 64'(ifu_req_ready), 64'(0));
    sb.push_back(exp_t'{1'b1, 32'h1122_3344, 1'b0});
    step();
    lsu_req_valid = 1'b0;
    #1;
    chk("tie1_grant", 64'(grant), 64'(2'b10));
    chk("tie1_ifu_ready_busy", 64'(ifu_req_ready), 64'(0));
    mem_serve(0, 0, 32'h1122_3344, 32'h8000_2000, 1'b0, '0, 8'h00, 3'b100);
    chk("tie1_lsu_resp", 64'({lsu_resp_valid, ifu_resp_valid}), 64'(2'b10));
    chk("tie1_ifu_ready_resp", 64'(ifu_req_ready), 64'(0));
    step();
    chk("tie1_grant_idle", 64'(grant), 64'(0));

    // Second tie goes to IFU; 3-cycle fetch latency, readop 010, wen 0.
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_2004; lsu_readop = 3'b010;
    #1;
    chk("tie2_ifu_ready", 64'(ifu_req_ready), 64'(1));
    chk("tie2_lsu_ready", 64'(lsu_req_ready), 64'(0));
    sb.push_back(exp_t'{1'b0, 32'h0000_0413, 1'b0});
    step();
    ifu_req_valid = 1'b0;
    #1;
    chk("tie2_grant", 64'(grant), 64'(2'b01));
    chk("tie2_lsu_ready_busy", 64'(lsu_req_ready), 64'(0));
    chk("ifu_resp_early", 64'(ifu_resp_valid), 64'(0));
    mem_serve(0, 0, 32'h0000_0413, 32'h8000_0000, 1'b0, '0, 8'h00, 3'b010);
    chk("ifu_resp_lat3", 64'({ifu_resp_valid, lsu_resp_valid, ifu_resp_err}), 64'(3'b100));
    step();

    // Third tie goes back to LSU.
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0004;
    #1;
    chk("tie3_lsu_ready", 64'(lsu_req_ready), 64'(1));
    chk("tie3_ifu_ready", 64'(ifu_req_ready), 64'(0));
    sb.push_back(exp_t'{1'b1, 32'h5566_7788, 1'b0});
    step();
    lsu_req_valid = 1'b0; ifu_req_valid = 1'b0;
    mem_serve(0, 1, 32'h5566_7788, 32'h8000_2004, 1'b0, '0, 8'h00, 3'b010);
    chk("tie3_lsu_resp", 64'(lsu_resp_valid), 64'(1));
    step();
    chk("lsu_rdata_hold", 64'(lsu_rdata), 64'(32'h5566_7788));

    // Watchdog: memory accepts but never answers; late response ignored.
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_3000; lsu_readop = 3'b000;
    sb.push_back(exp_t'{1'b1, 32'h0, 1'b1});
    step();
    lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("tout_no_resp_yet", 64'(lsu_resp_valid), 64'(0));
    end
    step();
    chk("tout_resp", 64'({lsu_resp_valid, lsu_resp_err}), 64'(2'b11));
    chk("tout_rdata_zero", 64'(lsu_rdata), 64'(0));
    mem_resp_valid = 1'b1; mem_rdata = 32'h1234_5678;
    step();
    mem_resp_valid = 1'b0; mem_rdata = '0;
    chk("tout_late_grant", 64'(grant), 64'(0));
    chk("tout_late_resp", 64'(lsu_resp_valid), 64'(0));
    step();
    chk("tout_late_idle", 64'({lsu_resp_valid, mem_req_valid}), 64'(0));
    chk("tout_late_rdata", 64'(lsu_rdata), 64'(0));

    // Store with mem_req_ready stalled 4 cycles; fields must stay put.
    lsu_req_valid = 1'b1; lsu_wen = 1'b1; lsu_addr = 32'h8000_1000;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 8'h0F; lsu_readop = 3'b010;
    #1;
    chk("st_lsu_ready", 64'(lsu_req_ready), 64'(1));
    sb.push_back(exp_t'{1'b1, 32'h0, 1'b0});
    step();
    lsu_req_valid = 1'b0; lsu_wen = 1'b0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0;
    mem_serve(4, 0, 32'hCAFE_F00D, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 8'h0F, 3'b010);
    chk("st_resp", 64'(lsu_resp_valid), 64'(1));
    step();
    chk("ifu_rdata_hold", 64'(ifu_rdata), 64'(32'h0000_0413));

    // Reset during WAIT drops the transaction; a new fetch then works.
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0100;
    step();
    ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    chk("rw_in_wait", 64'({mem_req_valid, grant}), 64'(3'b001));
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("rw_grant", 64'(grant), 64'(0));
    chk("rw_outputs", 64'({mem_req_valid, ifu_resp_valid, lsu_resp_valid, ifu_req_ready, lsu_req_ready}), 64'(0));
    chk("rw_mem_fields", 64'({mem_addr, mem_wen, mem_wmask, mem_readop}), 64'(0));
    chk("rw_rdata", 64'({ifu_rdata, lsu_rdata}), 64'(0));
    mem_resp_valid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    step();
    mem_resp_valid = 1'b0; mem_rdata = '0;
    chk("rw_no_resp", 64'(ifu_resp_valid), 64'(0));
    step();
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
    #1;
    chk("rw_new_ready", 64'(ifu_req_ready), 64'(1));
    sb.push_back(exp_t'{1'b0, 32'h0010_0093, 1'b0});
    step();
    ifu_req_valid = 1'b0;
    mem_serve(0, 0, 32'h0010_0093, 32'h8000_0000, 1'b0, '0, 8'h00, 3'b010);
    chk("rw_new_resp", 64'({ifu_resp_valid, lsu_resp_valid}), 64'(2'b10));
    step();

    // Response and watchdog land in the same WAIT cycle: the response wins.
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0200;
    sb.push_back(exp_t'{1'b0, 32'hA5A5_A5A5, 1'b0});
    step();
    ifu_req_valid = 1'b0;
    mem_serve(0, 6, 32'hA5A5_A5A5, 32'h8000_0200, 1'b0, '0, 8'h00, 3'b010);
    chk("race_resp", 64'({ifu_resp_valid, ifu_resp_err}), 64'(2'b10));
    step();
    step();

    chk("sb_empty", 64'(sb.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
